// File: rtl/retire_trace_collector.sv
// Retirement trace collector: stamps each retired record with a sequence number and
// buffers it in a first-word-fall-through FIFO. Optional shadow RF: TRACE_SHADOW_RF_EN.
module retire_trace_collector #(
   parameter int DEPTH        = 16,
   parameter int DROP_BUBBLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       update_i,
   input  logic [31:0]                pc_i,
   input  logic [31:0]                instr_i,
   input  logic [4:0]                 reg_addr_i,
   input  logic [31:0]                reg_data_i,
   input  logic [31:0]                mem_addr_i,
   input  logic [31:0]                mem_data_i,
   input  logic                       mem_wrt_i,
   input  logic                       clear_i,
   output logic                       rec_valid_o,
   input  logic                       rec_ready_i,
   output logic [31:0]                rec_seq_o,
   output logic [31:0]                rec_pc_o,
   output logic [31:0]                rec_instr_o,
   output logic [31:0]                rec_reg_data_o,
   output logic [31:0]                rec_mem_addr_o,
   output logic [31:0]                rec_mem_data_o,
   output logic [4:0]                 rec_reg_addr_o,
   output logic                       rec_mem_wrt_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic [CNT_W-1:0]           drop_cnt_o,
   input  logic [4:0]                 shadow_addr_i,
   output logic [31:0]                shadow_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] regData;
      logic [31:0] memAddr;
      logic [31:0] memData;
      logic [4:0]  regAddr;
      logic        memWrt;
   } rec_t;

   rec_t              r_mem [DEPTH];
   logic [AW-1:0]     r_rdPtr;
   logic [AW-1:0]     r_wrPtr;
   logic [CW-1:0]     r_count;
   logic [31:0]       r_seq;
   logic              r_overflow;
   logic [CNT_W-1:0]  r_dropCnt;

   logic              w_cand;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   rec_t              w_newRec;
   rec_t              w_head;

   // Flushed slots carry an all-ones PC and are ignored entirely when bubbles are dropped.
   assign w_cand = update_i && !((DROP_BUBBLES != 0) && (pc_i == 32'hFFFF_FFFF));
   assign w_full = (r_count == CW'(DEPTH));
   assign w_pop  = (r_count != '0) && rec_ready_i;
   assign w_push = w_cand && (!w_full || w_pop);
   assign w_drop = w_cand && w_full && !w_pop;

   assign w_newRec = '{seq: r_seq, pc: pc_i, instr: instr_i, regData: reg_data_i,
                       memAddr: mem_addr_i, memData: mem_data_i, regAddr: reg_addr_i,
                       memWrt: mem_wrt_i};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_seq      <= '0;
         r_overflow <= 1'b0;
         r_dropCnt  <= '0;
      end else if (clear_i) begin
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_dropCnt  <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         if (w_cand) r_seq   <= r_seq + 32'd1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCnt != '1) r_dropCnt <= r_dropCnt + 1'b1;
         end
      end
   end

   // Record storage carries no reset; entries are only read once the count covers them.
   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wrPtr] <= w_newRec;
   end

   assign w_head         = r_mem[r_rdPtr];
   assign rec_valid_o    = (r_count != '0);
   assign rec_seq_o      = w_head.seq;
   assign rec_pc_o       = w_head.pc;
   assign rec_instr_o    = w_head.instr;
   assign rec_reg_data_o = w_head.regData;
   assign rec_mem_addr_o = w_head.memAddr;
   assign rec_mem_data_o = w_head.memData;
   assign rec_reg_addr_o = w_head.regAddr;
   assign rec_mem_wrt_o  = w_head.memWrt;
   assign count_o        = r_count;
   assign overflow_o     = r_overflow;
   assign drop_cnt_o     = r_dropCnt;

`ifdef TRACE_SHADOW_RF_EN
   logic [31:0] r_shadow [32];

   // Shadow RF tracks every candidate write, independent of FIFO space or flushes.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
      end else if (w_cand && (reg_addr_i != 5'd0)) begin
         r_shadow[reg_addr_i] <= reg_data_i;
      end
   end

   assign shadow_data_o = (shadow_addr_i == 5'd0) ? 32'h0 : r_shadow[shadow_addr_i];
`else
   logic [4:0] w_unusedShadowAddr;
   assign w_unusedShadowAddr = shadow_addr_i;
   assign shadow_data_o      = 32'h0;
`endif

endmodule

// File: tb/tb_retire_trace_collector.sv
// Randomized bench for retire_trace_collector with a queue-based reference model,
// plus directed scenarios for bubbles, overflow, full-with-pop, clear and reset.
module tb_retire_trace_collector;

   localparam int DEPTH = 16;
   localparam int CNT_W = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rstn_i;
   logic update_i;
   logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
   logic [4:0]  reg_addr_i;
   logic        mem_wrt_i, clear_i, rec_ready_i;
   logic [4:0]  shadow_addr_i;
   logic        rec_valid_o, rec_mem_wrt_o, overflow_o;
   logic [31:0] rec_seq_o, rec_pc_o, rec_instr_o, rec_reg_data_o, rec_mem_addr_o, rec_mem_data_o;
   logic [4:0]  rec_reg_addr_o;
   logic [CW-1:0]    count_o;
   logic [CNT_W-1:0] drop_cnt_o;
   logic [31:0] shadow_data_o;

   retire_trace_collector #(.DEPTH(DEPTH), .DROP_BUBBLES(1), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
      .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
      .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i), .clear_i(clear_i),
      .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_seq_o(rec_seq_o),
      .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o), .rec_reg_data_o(rec_reg_data_o),
      .rec_mem_addr_o(rec_mem_addr_o), .rec_mem_data_o(rec_mem_data_o),
      .rec_reg_addr_o(rec_reg_addr_o), .rec_mem_wrt_o(rec_mem_wrt_o), .count_o(count_o),
      .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .shadow_addr_i(shadow_addr_i),
      .shadow_data_o(shadow_data_o));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] seq, pc, instr, regData, memAddr, memData;
      logic [4:0]  regAddr;
      logic        memWrt;
   } rec_t;

   rec_t        modelQ[$];
   int unsigned modelSeq;
   bit          modelOvf;
   int          modelDrops;
   logic [31:0] modelShadow [32];
   int          shadowSel = -1;
   int          nCompared = 0;
   int          nMismatched = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [31:0] expShadow(input logic [4:0] a);
`ifdef TRACE_SHADOW_RF_EN
      return (a == 5'd0) ? 32'h0 : modelShadow[a];
`else
      return 32'h0;
`endif
   endfunction

   // Reference behaviour at one rising edge, computed from the bench's own inputs.
   function automatic void modelStep();
      bit   cand;
      bit   popping;
      rec_t r;
      cand = update_i && (pc_i != 32'hFFFF_FFFF);
      if (cand && reg_addr_i != 5'd0) modelShadow[reg_addr_i] = reg_data_i;
      if (clear_i) begin
         modelQ.delete();
         modelOvf   = 1'b0;
         modelDrops = 0;
      end else begin
         popping = (modelQ.size() > 0) && rec_ready_i;
         if (popping) void'(modelQ.pop_front());
         if (cand) begin
            r = '{seq: modelSeq, pc: pc_i, instr: instr_i, regData: reg_data_i,
                  memAddr: mem_addr_i, memData: mem_data_i, regAddr: reg_addr_i,
                  memWrt: mem_wrt_i};
            if (modelQ.size() < DEPTH) modelQ.push_back(r);
            else begin
               modelOvf = 1'b1;
               if (modelDrops < (2 ** CNT_W) - 1) modelDrops++;
            end
            modelSeq++;
         end
      end
   endfunction

   task automatic checkAll();
      checkOutput("valid", rec_valid_o, modelQ.size() != 0);
      checkOutput("count", count_o, modelQ.size());
      checkOutput("overflow", overflow_o, modelOvf);
      checkOutput("drop_cnt", drop_cnt_o, modelDrops);
      checkOutput("shadow", shadow_data_o, expShadow(shadow_addr_i));
      if (modelQ.size() != 0) begin
         checkOutput("head_seq", rec_seq_o, modelQ[0].seq);
         checkOutput("head_pc", rec_pc_o, modelQ[0].pc);
         checkOutput("head_instr", rec_instr_o, modelQ[0].instr);
         checkOutput("head_rd", rec_reg_addr_o, modelQ[0].regAddr);
         checkOutput("head_rdata", rec_reg_data_o, modelQ[0].regData);
         checkOutput("head_maddr", rec_mem_addr_o, modelQ[0].memAddr);
         checkOutput("head_mdata", rec_mem_data_o, modelQ[0].memData);
         checkOutput("head_mwrt", rec_mem_wrt_o, modelQ[0].memWrt);
      end
   endtask

   // One clock cycle: drive after the falling edge, verify pre-edge state, step the model.
   task automatic applyStimulus(input bit upd, input logic [31:0] pcV, input bit rdy,
                                input bit clr, input logic [4:0] ra, input logic [31:0] rd);
      update_i      = upd;
      pc_i          = pcV;
      instr_i       = $urandom;
      reg_addr_i    = ra;
      reg_data_i    = rd;
      mem_addr_i    = $urandom;
      mem_data_i    = $urandom;
      mem_wrt_i     = 1'($urandom_range(0, 1));
      rec_ready_i   = rdy;
      clear_i       = clr;
      shadow_addr_i = (shadowSel < 0) ? 5'($urandom_range(0, 31)) : 5'(shadowSel);
      #1;
      checkOutput("valid_pre", rec_valid_o, modelQ.size() != 0);
      checkOutput("shadow_old", shadow_data_o, expShadow(shadow_addr_i));
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   task automatic simpleCycle(input bit upd, input logic [31:0] pcV, input bit rdy, input bit clr);
      applyStimulus(upd, pcV, rdy, clr, 5'($urandom_range(0, 31)), $urandom);
   endtask

   task automatic randomCycle(input int updPct, input int rdyPct, input int clrPct);
      bit upd, rdy, clr;
      logic [31:0] pcV;
      upd = ($urandom_range(0, 99) < updPct);
      rdy = ($urandom_range(0, 99) < rdyPct);
      clr = ($urandom_range(0, 99) < clrPct);
      pcV = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      simpleCycle(upd, pcV, rdy, clr);
   endtask

   task automatic doReset();
      #2 rstn_i = 1'b0;
      update_i = 1'b0; clear_i = 1'b0; rec_ready_i = 1'b0;
      modelQ.delete();
      modelSeq = 0; modelOvf = 1'b0; modelDrops = 0;
      for (int i = 0; i < 32; i++) modelShadow[i] = 32'h0;
      #2;
      checkOutput("rst_count", count_o, 0);
      checkOutput("rst_valid", rec_valid_o, 0);
      checkOutput("rst_shadow", shadow_data_o, 0);
      @(negedge clk);
      rstn_i = 1'b1;
      @(negedge clk);
      checkAll();
   endtask

   initial begin
      int unsigned preSeq;
      rstn_i = 1'b0; update_i = 1'b0; pc_i = '0; instr_i = '0; reg_addr_i = '0;
      reg_data_i = '0; mem_addr_i = '0; mem_data_i = '0; mem_wrt_i = 1'b0;
      clear_i = 1'b0; rec_ready_i = 1'b0; shadow_addr_i = '0;
      @(negedge clk);
      doReset();
      checkOutput("rst_ovf", overflow_o, 0);
      checkOutput("rst_drop", drop_cnt_o, 0);

      $display("[TB] three records then drain");
      for (int i = 0; i < 3; i++) simpleCycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
      checkOutput("tp1_count", count_o, 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput("tp1_seq", rec_seq_o, i);
         checkOutput("tp1_pc", rec_pc_o, 4 * i);
         simpleCycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("tp1_empty", rec_valid_o, 0);

      $display("[TB] bubble discard");
      doReset();
      simpleCycle(1'b1, 32'h10, 1'b0, 1'b0);
      simpleCycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      simpleCycle(1'b1, 32'h14, 1'b0, 1'b0);
      checkOutput("bub_count", count_o, 2);
      checkOutput("bub_seq0", rec_seq_o, 0);
      simpleCycle(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("bub_seq1", rec_seq_o, 1);
      checkOutput("bub_pc1", rec_pc_o, 32'h14);
      simpleCycle(1'b0, 32'h0, 1'b1, 1'b0);

      $display("[TB] overflow");
      doReset();
      for (int i = 0; i < 20; i++) simpleCycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
      checkOutput("ovf_count", count_o, 16);
      checkOutput("ovf_flag", overflow_o, 1);
      checkOutput("ovf_drops", drop_cnt_o, 4);
      for (int i = 0; i < 16; i++) begin
         checkOutput("ovf_drain_seq", rec_seq_o, i);
         simpleCycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
      simpleCycle(1'b1, 32'h100, 1'b0, 1'b0);
      checkOutput("ovf_next_seq", rec_seq_o, 20);

      $display("[TB] full with simultaneous push and pop");
      for (int i = 0; i < 15; i++) simpleCycle(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      checkOutput("fp_full", count_o, 16);
      simpleCycle(1'b1, 32'hABC, 1'b1, 1'b0);
      checkOutput("fp_count", count_o, 16);
      checkOutput("fp_drops", drop_cnt_o, 4);
      checkOutput("fp_head", rec_seq_o, 21);

      $display("[TB] clear with concurrent update");
      for (int i = 0; i < 11; i++) simpleCycle(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("clr_pre_count", count_o, 5);
      preSeq = modelSeq;
      simpleCycle(1'b1, 32'h300, 1'b0, 1'b1);
      checkOutput("clr_count", count_o, 0);
      checkOutput("clr_ovf", overflow_o, 0);
      checkOutput("clr_drops", drop_cnt_o, 0);
      simpleCycle(1'b1, 32'h304, 1'b0, 1'b0);
      checkOutput("clr_seq", rec_seq_o, preSeq);

      $display("[TB] drop counter saturation");
      for (int i = 0; i < 40; i++) simpleCycle(1'b1, $urandom & 32'h7FFF_FFFF, 1'b0, 1'b0);
      checkOutput("sat_drops", drop_cnt_o, 15);

      $display("[TB] shadow register file");
      shadowSel = 5;
      applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
`ifdef TRACE_SHADOW_RF_EN
      checkOutput("shadow_rd5", shadow_data_o, 32'hDEAD_BEEF);
`else
      checkOutput("shadow_tied", shadow_data_o, 32'h0);
`endif
      shadowSel = 0;
      applyStimulus(1'b1, 32'h404, 1'b1, 1'b0, 5'd0, 32'h1);
      checkOutput("shadow_rd0", shadow_data_o, 32'h0);
      shadowSel = -1;

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) randomCycle(70, 60, 1);
      for (int i = 0; i < 1000; i++) randomCycle(80, 20, 1);
      for (int i = 0; i < 1000; i++) randomCycle(100, 100, 0);

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 8; i++) randomCycle(90, 10, 0);
      doReset();
      for (int i = 0; i < 500; i++) randomCycle(60, 50, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/retire_trace_collector.md
# retire_trace_collector

Consumer for the core's retirement trace port. Samples one retirement record per `update_i` cycle and buffers it in a first-word-fall-through FIFO. Each record is tagged with a sequence number, and records are drained over a valid/ready port by the testbench logger or a debug bridge. Sits beside the pipelined RV32I top, wired directly to its retire outputs.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, 2..256.
- `DROP_BUBBLES`, 1, when 1, records with `pc_i == 32'hFFFFFFFF` (flushed slot) are discarded silently.
- `CNT_W`, 16, width of the saturating drop counter.

Ports:
- `clk_i` in 1: system clock; all state on rising edge.
- `rstn_i` in 1: asynchronous, active-low reset.
- `update_i` in 1: retire strobe; one record per high cycle.
- `pc_i` in 32: retired PC.
- `instr_i` in 32: retired instruction.
- `reg_addr_i` in 5: destination register.
- `reg_data_i` in 32: register write data.
- `mem_addr_i` in 32: data memory address.
- `mem_data_i` in 32: data memory write data.
- `mem_wrt_i` in 1: memory write enable.
- `clear_i` in 1: synchronous flush.
- `rec_valid_o` out 1: head record available.
- `rec_ready_i` in 1: consumer accepts head.
- `rec_seq_o` out 32: sequence number of head record.
- `rec_pc_o`, `rec_instr_o`, `rec_reg_data_o`, `rec_mem_addr_o`, `rec_mem_data_o` out 32 each: head record fields.
- `rec_reg_addr_o` out 5, `rec_mem_wrt_o` out 1: head record fields.
- `count_o` out $clog2(DEPTH)+1: occupancy.
- `overflow_o` out 1: sticky; at least one record dropped.
- `drop_cnt_o` out CNT_W: dropped-record count, saturating.
- `shadow_addr_i` in 5, `shadow_data_o` out 32: shadow register file read port (see Configuration).

## Operation
- Candidate record: `update_i`=1 and not (`DROP_BUBBLES`=1 and `pc_i`==32'hFFFFFFFF). Bubbles touch no state.
- Pop: `rec_valid_o && rec_ready_i`. Head advances at the edge.
- Push accepted when candidate and (`count_o` < DEPTH or pop in the same cycle). Full with simultaneous pop: push and pop both occur and count is unchanged.
- Candidate while full and not popping:
  - record is dropped;
  - `overflow_o` is set;
  - `drop_cnt_o` increments, saturating at all-ones.
- Sequence counter `seq`: 32 bits, starts at 0.
  - Every candidate (accepted or dropped) is stamped with the current `seq`, then `seq` increments, wrapping at 2^32.
  - Dropped records therefore show as gaps in `rec_seq_o`.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `count_o` is tracked separately so full and empty are distinguishable.
- Head fields come combinationally from storage at the read pointer. Fields are don't-care when `rec_valid_o`=0.
- `clear_i` has priority over push and pop in the same cycle. At the edge it:
  - empties the FIFO and zeroes both pointers;
  - clears `overflow_o` and `drop_cnt_o`;
  - leaves `seq` unchanged, and the candidate in that cycle consumes no sequence number.
- `rec_valid_o` = (`count_o` != 0).

## Timing
- Reset (async assert, sync release): `count_o`=0, `rec_valid_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `seq`=0, pointers=0, `shadow_data_o`=0. Reset mid-stream discards all buffered records.
- Push latency: a record sampled at edge T is visible on `rec_valid_o`/fields after edge T (same cycle as T+1 setup). No combinational path from `update_i` to `rec_valid_o`.
- Pop is single-cycle: the next head is presented immediately after the popping edge.
- Ready may be held high continuously, giving one pop per cycle. Sustained throughput is one record per cycle.
- Empty with push in the same cycle: no bypass; the record appears the next cycle.

## Configuration
- `TRACE_SHADOW_RF_EN` defined:
  - 32x32 shadow register file, reset to all zero.
  - Written at the edge on every candidate with `reg_addr_i` != 0, regardless of FIFO full or `clear_i`.
  - `shadow_data_o` = shadow[`shadow_addr_i`], combinational. Address 0 reads 0.
  - Same-cycle write and read of one address returns the old value.
- Undefined: no shadow storage; `shadow_data_o` tied to 32'h0; `shadow_addr_i` unused.

## Test plan
- Reset, then three updates with pc 0x0, 0x4, 0x8 and `rec_ready_i`=0 → `count_o`=3. Then ready=1 → pops pc 0x0, 0x4, 0x8 with seq 0, 1, 2 on consecutive cycles, then `rec_valid_o`=0.
- Update with pc 32'hFFFFFFFF between pc 0x10 and 0x14 (`DROP_BUBBLES`=1) → two records, seq 0 and 1, with no gap.
- DEPTH=16 and ready=0, 20 updates → `count_o`=16, `overflow_o`=1, `drop_cnt_o`=4. Drain yields seq 0..15. Next accepted record has seq 20.
- Full FIFO with simultaneous update and pop → `count_o` stays 16, no drop, new record appears at tail.
- Assert `clear_i` with a concurrent update while `count_o`=5 → `count_o`=0, `overflow_o`=0, `drop_cnt_o`=0. Next record's seq continues from the pre-clear value.
- With `TRACE_SHADOW_RF_EN`:
  - update with rd=5, data 0xDEADBEEF → `shadow_addr_i`=5 reads 0xDEADBEEF next cycle;
  - update with rd=0, data 0x1 → address 0 reads 0.
